// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Handles stall, branch/jump redirect with flush, and terminate-driven drain to done.
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jump_address,
  input  logic        terminate,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] pc4_id,
  output logic        valid_id,
  output logic        done,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  localparam logic [3:0] DrainLast = 4'(DRAIN_CYCLES);

  state_e      state;
  logic [3:0]  drain_cnt;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_bits;

  assign imem_addr     = pc;
  assign pc_plus4      = pc + 32'd4;
  // Redirect targets are relative to the branch/jump's own PC+4, held in IF/ID.
  assign branch_target = pc4_id + {branch_offset[29:0], 2'b00};
  assign jump_target   = {pc4_id[31:28], jump_address[25:0], 2'b00};
  assign unused_bits   = ^{branch_offset[31:30], jump_address[31:26]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StRun;
      drain_cnt   <= 4'd0;
      pc          <= RESET_PC;
      instruction <= 32'd0;
      pc4_id      <= 32'd0;
      valid_id    <= 1'b0;
      done        <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        StRun: begin
          if (!stall) begin
            if (terminate) begin
              state       <= StDrain;
              drain_cnt   <= 4'd1;
              instruction <= 32'd0;
              pc4_id      <= 32'd0;
              valid_id    <= 1'b0;
            end else if (jump_taken || branch_taken) begin
              pc          <= jump_taken ? jump_target : branch_target;
              instruction <= 32'd0;
              pc4_id      <= 32'd0;
              valid_id    <= 1'b0;
            end else begin
              pc          <= pc_plus4;
              instruction <= imem_rdata;
              pc4_id      <= pc_plus4;
              valid_id    <= 1'b1;
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        StDrain: begin
          instruction <= 32'd0;
          pc4_id      <= 32'd0;
          valid_id    <= 1'b0;
          if (drain_cnt == DrainLast) begin
            state <= StDone;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        StDone: begin
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table over a continuous run plus
// hand-written reset, wrap and mid-drain sequences.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic        jump_taken;
  logic [31:0] branch_offset;
  logic [31:0] jump_address;
  logic        terminate;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] pc4_id;
  logic        valid_id;
  logic        done;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  if_stage #(
    .RESET_PC    (32'h0000_0000),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump_taken   (jump_taken),
    .branch_offset(branch_offset),
    .jump_address (jump_address),
    .terminate    (terminate),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .pc4_id       (pc4_id),
    .valid_id     (valid_id),
    .done         (done),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic        jmp;
    logic        term;
    logic [31:0] off;
    logic [31:0] jaddr;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_done;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic b, logic j, logic t, logic [31:0] off,
                              logic [31:0] ja, logic [31:0] rd, logic [31:0] epc,
                              logic [31:0] ein, logic [31:0] ep4, logic ev, logic ed,
                              logic [31:0] ec);
    vec_t v;
    v.stall = s; v.br = b; v.jmp = j; v.term = t;
    v.off = off; v.jaddr = ja; v.rdata = rd;
    v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4;
    v.e_valid = ev; v.e_done = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [31:0] epc, logic [31:0] ein, logic [31:0] ep4,
                           logic ev, logic ed, logic [31:0] ec);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".imem_addr"}, imem_addr, epc);
    chk({tag, ".instruction"}, instruction, ein);
    chk({tag, ".pc4_id"}, pc4_id, ep4);
    chk({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, ev});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".fetch_count"}, fetch_count, ec);
  endtask

  task automatic drive(logic r, logic s, logic b, logic j, logic t, logic [31:0] off,
                       logic [31:0] ja, logic [31:0] rd);
    rst = r; stall = s; branch_taken = b; jump_taken = j; terminate = t;
    branch_offset = off; jump_address = ja; imem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    //       stall br  jmp term off           jaddr   rdata          pc            instr         pc4           v     d     cnt
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h2001000A, 32'h4,        32'h2001000A, 32'h4,        1'b1, 1'b0, 32'd1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h20020005, 32'h8,        32'h20020005, 32'h8,        1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,  32'h00221820, 32'h8,        32'h20020005, 32'h8,        1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(1, 1, 0, 0, 32'hFFFFFFFE, 32'h0,  32'h00221820, 32'h8,        32'h20020005, 32'h8,        1'b1, 1'b0, 32'd2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h00221820, 32'hC,        32'h00221820, 32'hC,        1'b1, 1'b0, 32'd3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h8C010000, 32'h10,       32'h8C010000, 32'h10,       1'b1, 1'b0, 32'd4));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h40, 32'h55555555, 32'h100,      32'h0,        32'h0,        1'b0, 1'b0, 32'd4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h11111111, 32'h104,      32'h11111111, 32'h104,      1'b1, 1'b0, 32'd5));
    vecs.push_back(mk(0, 1, 0, 0, 32'hFFFFFFFE, 32'h0,  32'h55555555, 32'hFC,       32'h0,        32'h0,        1'b0, 1'b0, 32'd5));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h22222222, 32'h100,      32'h22222222, 32'h100,      1'b1, 1'b0, 32'd6));
    // Branch alone would land at 0x140; jump must win.
    vecs.push_back(mk(0, 1, 1, 0, 32'h10,       32'h5,  32'h55555555, 32'h14,       32'h0,        32'h0,        1'b0, 1'b0, 32'd6));
    vecs.push_back(mk(0, 1, 0, 1, 32'h10,       32'h0,  32'h33333333, 32'h14,       32'h0,        32'h0,        1'b0, 1'b0, 32'd6));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,        32'h5,  32'h33333333, 32'h14,       32'h0,        32'h0,        1'b0, 1'b0, 32'd6));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,  32'h44444444, 32'h14,       32'h0,        32'h0,        1'b0, 1'b0, 32'd6));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        32'h0,  32'h44444444, 32'h14,       32'h0,        32'h0,        1'b0, 1'b0, 32'd6));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h40, 32'h44444444, 32'h14,       32'h0,        32'h0,        1'b0, 1'b1, 32'd6));
    vecs.push_back(mk(0, 1, 0, 0, 32'h10,       32'h0,  32'h44444444, 32'h14,       32'h0,        32'h0,        1'b0, 1'b1, 32'd6));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].term, vecs[i].off,
            vecs[i].jaddr, vecs[i].rdata);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                vecs[i].e_valid, vecs[i].e_done, vecs[i].e_cnt);
    end

    // Reset out of DONE, then branch to the top word and wrap to zero.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hDEADBEEF);
    step();
    check_all("rst_done", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0001);
    step();
    check_all("w1", 32'h4, 32'hAAAA0001, 32'h4, 1'b1, 1'b0, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0002);
    step();
    check_all("w2", 32'h8, 32'hAAAA0002, 32'h8, 1'b1, 1'b0, 32'd2);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd0, 32'hAAAAFFFF);
    step();
    check_all("w_br", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0003);
    step();
    check_all("w_wrap", 32'h0, 32'hAAAA0003, 32'h0, 1'b1, 1'b0, 32'd3);

    // Reset mid-drain.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'hAAAA0004);
    step();
    check_all("d_term", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0004);
    step();
    check_all("d_drain", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0004);
    step();
    check_all("d_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0005);
    step();
    check_all("d_restart", 32'h4, 32'hAAAA0005, 32'h4, 1'b1, 1'b0, 32'd1);

    // Reset wins over stall.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hAAAA0006);
    step();
    check_all("s_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
